branch_resolve_bht: RTL and testbench
=====================================

// Module: branch_resolve_bht
// PURPOSE
//  ID-stage branch/jump resolution unit with a branch history table (BHT) of 2-bit saturating counters.
//  Fetch reads a taken/not-taken prediction from the BHT. ID resolves the branch, compares the outcome
//  with the prediction carried down from IF, and updates the BHT.
//  On a mispredict it raises a registered redirect request to fetch (valid/ready) and stalls ID until the
//  redirect is accepted. Keeps branch and mispredict counters for performance monitoring.
// PARAMETERS
//  DATA_W      32  width of reg_rs/reg_rt operands
//  PC_W        32  width of all PC/target buses
//  BHT_ENTRIES 64  number of 2-bit counters; power of 2, >=2; index = pc[IDX_W+1:2]
//  CNT_W       32  width of the performance counters
// PORTS
//  clk             in   1            clock, all state on rising edge
//  rst             in   1            synchronous, active-high reset
//  if_pc           in   PC_W         fetch PC for prediction lookup
//  if_pred_taken   out  1            BHT prediction for if_pc (combinational, counter[1])
//  id_valid        in   1            branch/jump instruction present in ID this cycle
//  id_pc           in   PC_W         PC of the ID instruction
//  branch_type     in   4            branch encoding (BEQ..JALR, shared defines); others = not a branch
//  reg_rs          in   DATA_W       forwarded rs operand
//  reg_rt          in   DATA_W       forwarded rt operand
//  branch_target   in   PC_W         computed taken target (imm/jump/register)
//  id_pred_taken   in   1            prediction that IF used for this instruction
//  id_stall        out  1            ID must hold; instruction is not consumed
//  redirect_valid  out  1            redirect request to fetch
//  redirect_pc     out  PC_W         corrected fetch PC
//  redirect_ready  in   1            fetch accepts redirect
//  branch_cnt      out  CNT_W        resolved conditional branches + jumps
//  mispred_cnt     out  CNT_W        mispredicts
// BEHAVIOUR
//  Reset: redirect_valid=0, redirect_pc=0, counters=0, all BHT entries=2'b01 (weak not-taken),
//  FSM=IDLE. id_stall=0 after reset.
//  Taken rule (signed, DATA_W-wide):
//   - BEQ rs==rt; BNE rs!=rt
//   - BGEZ/BGEZAL rs>=0; BGTZ rs>0; BLEZ rs<=0; BLTZ/BLTZAL rs<0
//   - J/JAL/JR/JALR always taken
//   - any other code: not a branch, no action at all
//  Resolve event: id_valid & ~id_stall & branch code. Resolve handling is registered, at the same edge:
//   - branch_cnt++; actual outcome compared to id_pred_taken
//   - on mismatch: mispred_cnt++; redirect_pc <= taken ? branch_target : id_pc+8 (skip delay slot);
//     FSM -> REDIRECT
//  BHT update (conditional branches only; jumps never write the BHT):
//   - taken -> counter saturating increment to 2'b11
//   - not taken -> counter saturating decrement to 2'b00
//  BHT write/read same index, same cycle: if_pred_taken returns the OLD value (no bypass).
//  FSM:
//   - IDLE: redirect_valid=0 -> REDIRECT on mispredict
//   - REDIRECT: redirect_valid=1, redirect_pc stable until the handshake; redirect_valid & redirect_ready
//     -> IDLE on the next edge. Latency from resolve edge to redirect_valid = 1 cycle.
//  id_stall = (FSM==REDIRECT), combinational. A branch in ID while stalled is not resolved and not
//   counted; it is resolved in the first cycle after return to IDLE.
//  Counters saturate at all-ones; no wrap.
//  rst asserted in REDIRECT: request dropped next edge, BHT reinitialised.
//  BHT init runs in parallel in 1 cycle (flop array).
// STRUCTURE
//  Shared defines: branch_type encodings (BEQ..JALR) and the 2-bit counter reset value WEAK_NT.
//  One sub-module: branch_cond_eval (combinational taken evaluation: type, rs, rt -> taken, is_branch, is_cond).
//  The BHT array, FSM and counters stay in this module.
// TESTING
//  1 Reset, then BEQ rs=rt=5 at pc 0x100, id_pred_taken=0, target 0x200
//    -> next cycle redirect_valid=1, redirect_pc=0x200, id_stall=1, mispred_cnt=1.
//  2 BNE rs=rt=7, pred 0 -> no redirect; branch_cnt=1; BHT[idx(0x100)] 01->00;
//    if_pred_taken for 0x100 = 0.
//  3 Three taken BGTZ rs=1 at pc 0x40 -> counter 01->10->11->11 (saturates); if_pred_taken(0x40)=1
//    after first update.
//  4 BLTZ rs=0x8000_0000, pred 0, redirect_ready held 0 for 3 cycles -> redirect_valid/pc stable,
//    id_stall=1; second branch held, counted only after ready=1 handshake.
//  5 Not-taken BLEZ rs=3, pred 1, pc 0x300 -> redirect_pc=0x308.
//  6 JR with pred 0 -> redirect to target, BHT unchanged. rst asserted mid-REDIRECT -> redirect_valid=0
//    next cycle, all BHT entries read 0.

Source files
------------

// File: rtl/branch_resolve_bht_pkg.sv
// rtl/branch_resolve_bht_pkg.sv - branch encodings, BHT counter constants and FSM state type
package branch_resolve_bht_pkg;

    // Branch-type encodings shared by the ID stage and the resolution unit.
    // Any code not listed here means "not a branch".
    localparam logic [3:0] BR_NONE   = 4'd0;
    localparam logic [3:0] BR_BEQ    = 4'd1;
    localparam logic [3:0] BR_BNE    = 4'd2;
    localparam logic [3:0] BR_BGEZ   = 4'd3;
    localparam logic [3:0] BR_BGEZAL = 4'd4;
    localparam logic [3:0] BR_BGTZ   = 4'd5;
    localparam logic [3:0] BR_BLEZ   = 4'd6;
    localparam logic [3:0] BR_BLTZ   = 4'd7;
    localparam logic [3:0] BR_BLTZAL = 4'd8;
    localparam logic [3:0] BR_J      = 4'd9;
    localparam logic [3:0] BR_JAL    = 4'd10;
    localparam logic [3:0] BR_JR     = 4'd11;
    localparam logic [3:0] BR_JALR   = 4'd12;

    // 2-bit counter reset value: weak not-taken
    localparam logic [1:0] WEAK_NT = 2'b01;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    // Saturating 2-bit counter step toward the observed outcome
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11) begin
            nxt = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolve_bht_cond_eval.sv
// rtl/branch_resolve_bht_cond_eval.sv - combinational branch taken evaluation
// Ports:
//   i_branch_type  branch encoding
//   i_rs, i_rt     forwarded operands (compared as signed DATA_W values)
//   o_taken        branch outcome
//   o_is_branch    encoding is a conditional branch or a jump
//   o_is_cond      encoding is a conditional branch (updates the BHT)
module branch_cond_eval
    import branch_resolve_bht_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        i_branch_type,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
    output logic              o_taken,
    output logic              o_is_branch,
    output logic              o_is_cond
);

    // Sign and zero tests are enough for all the compare-against-zero forms
    logic w_rs_neg;
    logic w_rs_zero;

    assign w_rs_neg  = i_rs[DATA_W-1];
    assign w_rs_zero = ~|i_rs;

    always_comb begin
        o_taken     = 1'b0;
        o_is_branch = 1'b1;
        o_is_cond   = 1'b1;
        case (i_branch_type)
            BR_BEQ:              o_taken = (i_rs == i_rt);
            BR_BNE:              o_taken = (i_rs != i_rt);
            BR_BGEZ, BR_BGEZAL:  o_taken = ~w_rs_neg;
            BR_BGTZ:             o_taken = ~w_rs_neg & ~w_rs_zero;
            BR_BLEZ:             o_taken = w_rs_neg | w_rs_zero;
            BR_BLTZ, BR_BLTZAL:  o_taken = w_rs_neg;
            BR_J, BR_JAL, BR_JR, BR_JALR: begin
                o_taken   = 1'b1;
                o_is_cond = 1'b0;
            end
            default: begin
                o_is_branch = 1'b0;
                o_is_cond   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - ID-stage branch resolution with 2-bit BHT and redirect FSM
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_if_pc / o_if_pred_taken   fetch-side BHT lookup (combinational)
//   i_id_*                branch in ID: valid, pc, type, operands, target, IF prediction
//   o_id_stall            ID must hold while a redirect is outstanding
//   o_redirect_*          redirect request to fetch (valid/ready)
//   o_branch_cnt, o_mispred_cnt  saturating performance counters
module branch_resolve_bht
    import branch_resolve_bht_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [PC_W-1:0]   i_if_pc,
    output logic              o_if_pred_taken,
    input  logic              i_id_valid,
    input  logic [PC_W-1:0]   i_id_pc,
    input  logic [3:0]        i_branch_type,
    input  logic [DATA_W-1:0] i_reg_rs,
    input  logic [DATA_W-1:0] i_reg_rt,
    input  logic [PC_W-1:0]   i_branch_target,
    input  logic              i_id_pred_taken,
    output logic              o_id_stall,
    output logic              o_redirect_valid,
    output logic [PC_W-1:0]   o_redirect_pc,
    input  logic              i_redirect_ready,
    output logic [CNT_W-1:0]  o_branch_cnt,
    output logic [CNT_W-1:0]  o_mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       r_bht [BHT_ENTRIES];
    state_t           r_state;
    state_t           w_next_state;
    logic [PC_W-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_taken;
    logic             w_is_branch;
    logic             w_is_cond;
    logic             w_stall;
    logic             w_resolve;
    logic             w_mispred;
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_id_idx;
    logic             w_unused;

    // Word-aligned PCs: bits [1:0] never select an entry
    assign w_if_idx = i_if_pc[IDX_W+1:2];
    assign w_id_idx = i_id_pc[IDX_W+1:2];
    assign w_unused = ^{i_if_pc[PC_W-1:IDX_W+2], i_if_pc[1:0]};

    branch_cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond_eval (
        .i_branch_type (i_branch_type),
        .i_rs          (i_reg_rs),
        .i_rt          (i_reg_rt),
        .o_taken       (w_taken),
        .o_is_branch   (w_is_branch),
        .o_is_cond     (w_is_cond)
    );

    assign w_stall   = (r_state == ST_REDIRECT);
    assign w_resolve = i_id_valid & ~w_stall & w_is_branch;
    assign w_mispred = w_resolve & (w_taken != i_id_pred_taken);

    // Plain array read: a same-cycle update is seen by fetch one cycle later
    assign o_if_pred_taken = r_bht[w_if_idx][1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= WEAK_NT;
            end
        end else if (w_resolve && w_is_cond) begin
            r_bht[w_id_idx] <= ctr_update(r_bht[w_id_idx], w_taken);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mispred) begin
                    w_next_state = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (i_redirect_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Redirect PC only loads on a mispredict, which cannot happen while stalled,
    // so it stays stable for the whole REDIRECT request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_redirect_pc <= '0;
        end else if (w_mispred) begin
            r_redirect_pc <= w_taken ? i_branch_target : (i_id_pc + PC_W'(8));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolve && r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_mispred && r_mispred_cnt != '1) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
        end
    end

    assign o_id_stall       = w_stall;
    assign o_redirect_valid = (r_state == ST_REDIRECT);
    assign o_redirect_pc    = r_redirect_pc;
    assign o_branch_cnt     = r_branch_cnt;
    assign o_mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - directed self-checking bench for branch_resolve_bht
module tb_branch_resolve_bht;
    import branch_resolve_bht_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [3:0]  branch_type;
    logic [31:0] reg_rs;
    logic [31:0] reg_rt;
    logic [31:0] branch_target;
    logic        id_pred_taken;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolve_bht dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_if_pc         (if_pc),
        .o_if_pred_taken (if_pred_taken),
        .i_id_valid      (id_valid),
        .i_id_pc         (id_pc),
        .i_branch_type   (branch_type),
        .i_reg_rs        (reg_rs),
        .i_reg_rt        (reg_rt),
        .i_branch_target (branch_target),
        .i_id_pred_taken (id_pred_taken),
        .o_id_stall      (id_stall),
        .o_redirect_valid(redirect_valid),
        .o_redirect_pc   (redirect_pc),
        .i_redirect_ready(redirect_ready),
        .o_branch_cnt    (branch_cnt),
        .o_mispred_cnt   (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [3:0] t, input logic [31:0] pc, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] tgt, input logic pred);
        id_valid      = 1'b1;
        branch_type   = t;
        id_pc         = pc;
        reg_rs        = rs;
        reg_rt        = rt;
        branch_target = tgt;
        id_pred_taken = pred;
    endtask

    initial begin
        rst = 1'b1; if_pc = '0; id_valid = 1'b0; id_pc = '0; branch_type = BR_NONE;
        reg_rs = '0; reg_rt = '0; branch_target = '0; id_pred_taken = 1'b0; redirect_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        if_pc = 32'h100;
        #1;
        check("rst_valid", {31'b0, redirect_valid}, 32'd0);
        check("rst_pc", redirect_pc, 32'h0);
        check("rst_stall", {31'b0, id_stall}, 32'd0);
        check("rst_bcnt", branch_cnt, 32'd0);
        check("rst_mcnt", mispred_cnt, 32'd0);
        check("rst_pred", {31'b0, if_pred_taken}, 32'd0);

        // 1: taken BEQ predicted not-taken -> redirect to target
        set_br(BR_BEQ, 32'h100, 32'd5, 32'd5, 32'h200, 1'b0);
        step();
        id_valid = 1'b0;
        #1;
        check("t1_valid", {31'b0, redirect_valid}, 32'd1);
        check("t1_pc", redirect_pc, 32'h200);
        check("t1_stall", {31'b0, id_stall}, 32'd1);
        check("t1_mcnt", mispred_cnt, 32'd1);
        check("t1_bcnt", branch_cnt, 32'd1);
        check("t1_pred", {31'b0, if_pred_taken}, 32'd1);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check("t1_hs_valid", {31'b0, redirect_valid}, 32'd0);
        check("t1_hs_stall", {31'b0, id_stall}, 32'd0);

        // 2: fresh reset, not-taken BNE decrements 01->00
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_br(BR_BNE, 32'h100, 32'd7, 32'd7, 32'h200, 1'b0);
        step();
        check("t2_valid", {31'b0, redirect_valid}, 32'd0);
        check("t2_bcnt", branch_cnt, 32'd1);
        check("t2_mcnt", mispred_cnt, 32'd0);
        check("t2_pred", {31'b0, if_pred_taken}, 32'd0);
        // one taken update from 00 lands on 01, still not-taken
        set_br(BR_BEQ, 32'h100, 32'd3, 32'd3, 32'h200, 1'b1);
        step();
        check("t2_pred2", {31'b0, if_pred_taken}, 32'd0);
        check("t2_bcnt2", branch_cnt, 32'd2);

        // 3: BGTZ taken three times at 0x40, old value visible before the edge
        if_pc = 32'h40;
        set_br(BR_BGTZ, 32'h40, 32'd1, 32'd0, 32'h80, 1'b1);
        #1;
        check("t3_pred_old", {31'b0, if_pred_taken}, 32'd0);
        step();
        check("t3_pred1", {31'b0, if_pred_taken}, 32'd1);
        step();
        step();
        check("t3_bcnt", branch_cnt, 32'd5);
        check("t3_mcnt", mispred_cnt, 32'd0);
        // saturated at 11: one not-taken -> 10 (still taken), another -> 01
        set_br(BR_BGTZ, 32'h40, 32'd0, 32'd0, 32'h80, 1'b0);
        step();
        check("t3_sat_pred", {31'b0, if_pred_taken}, 32'd1);
        step();
        check("t3_dec_pred", {31'b0, if_pred_taken}, 32'd0);
        check("t3_bcnt2", branch_cnt, 32'd7);

        // 4: BLTZ on negative rs, ready held low; a second branch waits in ID
        set_br(BR_BLTZ, 32'h504, 32'h8000_0000, 32'd0, 32'h600, 1'b0);
        step();
        set_br(BR_BEQ, 32'h508, 32'd1, 32'd1, 32'h700, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t4_valid", {31'b0, redirect_valid}, 32'd1);
            check("t4_pc", redirect_pc, 32'h600);
            check("t4_stall", {31'b0, id_stall}, 32'd1);
            check("t4_bcnt_hold", branch_cnt, 32'd8);
            step();
        end
        check("t4_mcnt", mispred_cnt, 32'd1);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check("t4_hs_valid", {31'b0, redirect_valid}, 32'd0);
        check("t4_hs_bcnt", branch_cnt, 32'd8);
        step();
        id_valid = 1'b0;
        check("t4_second_bcnt", branch_cnt, 32'd9);
        check("t4_second_mcnt", mispred_cnt, 32'd1);
        check("t4_second_valid", {31'b0, redirect_valid}, 32'd0);

        // non-branch code: no action
        set_br(4'd15, 32'h300, 32'd0, 32'd0, 32'h0, 1'b1);
        step();
        check("nb_bcnt", branch_cnt, 32'd9);
        check("nb_valid", {31'b0, redirect_valid}, 32'd0);

        // 5: not-taken BLEZ predicted taken -> pc+8
        set_br(BR_BLEZ, 32'h300, 32'd3, 32'd0, 32'h400, 1'b1);
        step();
        id_valid = 1'b0;
        check("t5_pc", redirect_pc, 32'h308);
        check("t5_valid", {31'b0, redirect_valid}, 32'd1);
        check("t5_mcnt", mispred_cnt, 32'd2);
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;

        // 6: JR mispredicted, BHT untouched; reset mid-REDIRECT
        if_pc = 32'h810;
        set_br(BR_JR, 32'h810, 32'd0, 32'd0, 32'h1234, 1'b0);
        step();
        id_valid = 1'b0;
        check("t6_pc", redirect_pc, 32'h1234);
        check("t6_valid", {31'b0, redirect_valid}, 32'd1);
        check("t6_bcnt", branch_cnt, 32'd11);
        check("t6_mcnt", mispred_cnt, 32'd3);
        check("t6_bht_nowrite", {31'b0, if_pred_taken}, 32'd0);
        if_pc = 32'h504;
        #1;
        check("t6_pre_rst_pred", {31'b0, if_pred_taken}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t6_rst_valid", {31'b0, redirect_valid}, 32'd0);
        check("t6_rst_stall", {31'b0, id_stall}, 32'd0);
        check("t6_rst_pred", {31'b0, if_pred_taken}, 32'd0);
        check("t6_rst_bcnt", branch_cnt, 32'd0);
        check("t6_rst_mcnt", mispred_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
